// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM encoding and default widths.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_ADDR_W = 9;
  localparam int unsigned DEFAULT_DEPTH  = 512;

  function automatic int unsigned bytes_per_word(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Assembles a big-endian byte stream into DATA_W words; strobes the finished word
// combinationally in the cycle its last byte arrives.
module byte_packer
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_strobe_o,
  output logic              pending_o
);

  localparam int unsigned NBYTES = bytes_per_word(DATA_W);
  localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] word_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              last_byte;

  // Byte k of the word lands in the k-th most significant byte lane.
  always_comb begin
    word_d = acc_q;
    for (int k = 0; k < NBYTES; k++) begin
      if (byte_valid_i && (cnt_q == CNT_W'(k))) begin
        word_d[DATA_W-1-8*k -: 8] = byte_i;
      end
    end
  end

  assign last_byte = byte_valid_i && (cnt_q == CNT_W'(NBYTES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (last_byte) begin
      cnt_d = '0;
    end else if (byte_valid_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i || clear_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (byte_valid_i) begin
      acc_q <= last_byte ? '0 : word_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o        = word_d;
  assign word_strobe_o = last_byte;
  assign pending_o     = (cnt_d != '0);

endmodule

// File: rtl/instr_mem_loader.sv
// Instruction memory with a single-cycle fetch port and a byte-stream program loader
// that writes assembled words starting at address 0.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
  input  logic              ck,
  input  logic              rstn,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  input  logic              load_start,
  input  logic              load_byte_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_end,
  output logic              load_ready,
  output logic              load_done,
  output logic [ADDR_W:0]   load_words,
  output logic              busy
);

  localparam int unsigned    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

  if ((DATA_W == 0) || ((DATA_W % 8) != 0) || (DEPTH > (2 ** ADDR_W))) begin : g_bad_params
    $error("instr_mem_loader: DATA_W must be a multiple of 8 and DEPTH <= 2**ADDR_W");
  end

  state_e            state_q;
  logic [DATA_W-1:0] fetch_data_q;
  logic              fetch_valid_q;
  logic              load_ready_q;
  logic              load_done_q;
  logic              busy_q;
  logic [ADDR_W:0]   words_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] pack_word;
  logic              pack_strobe;
  logic              pack_pending;
  logic              pack_clear;
  logic              byte_accept;
  logic              wr_en;
  logic [ADDR_W:0]   words_inc;
  logic              in_range;

  assign byte_accept = load_byte_valid && load_ready_q;
  assign pack_clear  = ((state_q == IDLE) && load_start) || (state_q == FLUSH);
  assign words_inc   = words_q + ONE_W;
  assign in_range    = ({1'b0, fetch_addr} < DEPTH_W);

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clk_i         (ck),
    .rstn_i        (rstn),
    .clear_i       (pack_clear),
    .byte_valid_i  (byte_accept),
    .byte_i        (load_byte),
    .word_o        (pack_word),
    .word_strobe_o (pack_strobe),
    .pending_o     (pack_pending)
  );

  // In FLUSH the packer sees no byte, so its word output is the zero-padded partial word.
  assign wr_en = rstn && (((state_q == LOAD) && pack_strobe) || (state_q == FLUSH));

  always_ff @(posedge ck) begin
    if (wr_en) begin
      mem[words_q[IDX_W-1:0]] <= pack_word;
    end
  end

  always_ff @(posedge ck) begin
    if (!rstn) begin
      state_q       <= IDLE;
      fetch_data_q  <= '0;
      fetch_valid_q <= 1'b0;
      load_ready_q  <= 1'b0;
      load_done_q   <= 1'b0;
      busy_q        <= 1'b0;
      words_q       <= '0;
    end else begin
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (fetch_req) begin
            fetch_valid_q <= 1'b1;
            fetch_data_q  <= in_range ? mem[fetch_addr[IDX_W-1:0]] : '0;
          end
          if (load_start) begin
            state_q      <= LOAD;
            words_q      <= '0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        LOAD: begin
          if (pack_strobe) begin
            words_q <= words_inc;
          end
          // A full memory ends the load even if load_end arrives in the same cycle.
          if (pack_strobe && (words_inc == DEPTH_W)) begin
            state_q      <= IDLE;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            load_done_q  <= 1'b1;
          end else if (load_end) begin
            load_ready_q <= 1'b0;
            if (pack_pending) begin
              state_q <= FLUSH;
            end else begin
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              load_done_q <= 1'b1;
            end
          end
        end
        FLUSH: begin
          words_q     <= words_inc;
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          load_done_q <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          load_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign load_ready  = load_ready_q;
  assign load_done   = load_done_q;
  assign load_words  = words_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader using a small DEPTH so the full-memory stop is reachable.
module tb_instr_mem_loader;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int NB     = DATA_W / 8;

  logic              ck = 1'b0;
  logic              rstn = 1'b0;
  logic              fetch_req = 1'b0;
  logic [ADDR_W-1:0] fetch_addr = '0;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              load_start = 1'b0;
  logic              load_byte_valid = 1'b0;
  logic [7:0]        load_byte = '0;
  logic              load_end = 1'b0;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_words;
  logic              busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] model_mem [DEPTH];
  bit          model_wr  [DEPTH];
  int          model_words;

  int done_cnt;
  int done_after_bytes;
  int bytes_sent;

  instr_mem_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .ck              (ck),
    .rstn            (rstn),
    .fetch_req       (fetch_req),
    .fetch_addr      (fetch_addr),
    .fetch_data      (fetch_data),
    .fetch_valid     (fetch_valid),
    .load_start      (load_start),
    .load_byte_valid (load_byte_valid),
    .load_byte       (load_byte),
    .load_end        (load_end),
    .load_ready      (load_ready),
    .load_done       (load_done),
    .load_words      (load_words),
    .busy            (busy)
  );

  always #5 ck = ~ck;

  task automatic step();
    @(posedge ck);
    #1;
    if (load_done === 1'b1) begin
      done_cnt++;
      done_after_bytes = bytes_sent;
    end
  endtask

  // Reference: bytes fill words big-endian from address 0, zero-padded, capped at DEPTH words.
  function automatic void model_load(input logic [7:0] bq[$]);
    int n;
    int nw;
    logic [31:0] wd;
    n  = bq.size();
    nw = (n + NB - 1) / NB;
    if (nw > DEPTH) nw = DEPTH;
    for (int w = 0; w < nw; w++) begin
      wd = '0;
      for (int k = 0; k < NB; k++) begin
        if (w * NB + k < n) wd[31-8*k -: 8] = bq[w*NB+k];
      end
      model_mem[w] = wd;
      model_wr[w]  = 1'b1;
    end
    model_words = nw;
  endfunction

  task automatic run_load(input logic [7:0] bq[$], input bit merge_end, input bit poke_start,
                          input bit gaps);
    done_cnt = 0;
    bytes_sent = 0;
    done_after_bytes = -1;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    for (int i = 0; i < bq.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) step();
      load_byte_valid = 1'b1;
      load_byte       = bq[i];
      load_start      = poke_start && (i == 1);
      load_end        = merge_end && (i == bq.size() - 1);
      bytes_sent      = i + 1;
      step();
      load_byte_valid = 1'b0;
      load_start      = 1'b0;
      load_end        = 1'b0;
    end
    if (!merge_end || bq.size() == 0) begin
      load_end = 1'b1;
      step();
      load_end = 1'b0;
    end
    repeat (4) step();
  endtask

  task automatic do_fetch(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic v);
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    d = fetch_data;
    v = fetch_valid;
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    fetch_req = 1'b1;
    load_start = 1'b1;
    rstn = 1'b0;
    step();
    step();
    fetch_req = 1'b0;
    load_start = 1'b0;
    checks++; if (fetch_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_fetch_valid got=%b exp=0", fetch_valid); end
    checks++; if (fetch_data !== 32'h0) begin failures++; $display("[TB] FAIL reset_fetch_data got=%h exp=0", fetch_data); end
    checks++; if (load_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_load_ready got=%b exp=0", load_ready); end
    checks++; if (load_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_load_done got=%b exp=0", load_done); end
    checks++; if (load_words !== '0) begin failures++; $display("[TB] FAIL reset_load_words got=%0d exp=0", load_words); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_basic_load();
    logic [7:0] bq[$];
    logic [31:0] d;
    logic v;
    bq = '{8'h50, 8'h20, 8'h00, 8'h00, 8'h28, 8'h22, 8'h00, 8'h00};
    run_load(bq, 1'b0, 1'b0, 1'b0);
    model_load(bq);
    checks++; if (done_cnt !== 1) begin failures++; $display("[TB] FAIL basic_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (load_words !== 4'd2) begin failures++; $display("[TB] FAIL basic_words got=%0d exp=2", load_words); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL basic_busy got=%b exp=0", busy); end
    do_fetch(3'd0, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h50200000) begin failures++; $display("[TB] FAIL basic_fetch0 got=%b/%h exp=1/50200000", v, d); end
    do_fetch(3'd1, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h28220000) begin failures++; $display("[TB] FAIL basic_fetch1 got=%b/%h exp=1/28220000", v, d); end
    step();
    checks++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h28220000) begin failures++; $display("[TB] FAIL basic_fetch_idle got=%b/%h exp=0/28220000", fetch_valid, fetch_data); end
  endtask

  task automatic test_flush();
    logic [7:0] bq[$];
    logic [31:0] d;
    logic v;
    bq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    run_load(bq, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    model_load(bq);
    checks++; if (done_cnt !== 1) begin failures++; $display("[TB] FAIL flush_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (load_words !== 4'd2) begin failures++; $display("[TB] FAIL flush_words got=%0d exp=2", load_words); end
    do_fetch(3'd1, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h15000000) begin failures++; $display("[TB] FAIL flush_word1 got=%b/%h exp=1/15000000", v, d); end
    do_fetch(3'd0, d, v);
    checks++; if (v !== 1'b1 || d !== 32'h11121314) begin failures++; $display("[TB] FAIL flush_word0 got=%b/%h exp=1/11121314", v, d); end
  endtask

  task automatic test_full();
    logic [7:0] bq[$];
    logic [31:0] d;
    logic v;
    for (int i = 0; i < 20; i++) bq.push_back(8'($urandom_range(0, 255)));
    run_load(bq, 1'b0, 1'b0, 1'b1);
    model_load(bq);
    checks++; if (done_cnt !== 1) begin failures++; $display("[TB] FAIL full_done_pulses got=%0d exp=1", done_cnt); end
    checks++; if (done_after_bytes !== DEPTH * NB) begin failures++; $display("[TB] FAIL full_done_timing got=%0d exp=%0d", done_after_bytes, DEPTH * NB); end
    checks++; if (load_words !== 4'(DEPTH)) begin failures++; $display("[TB] FAIL full_words got=%0d exp=%0d", load_words, DEPTH); end
    checks++; if (load_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL full_idle got=%b/%b exp=0/0", load_ready, busy); end
    for (int a = 0; a < DEPTH; a++) begin
      do_fetch(3'(a), d, v);
      checks++; if (v !== 1'b1 || d !== model_mem[a]) begin failures++; $display("[TB] FAIL full_fetch%0d got=%b/%h exp=1/%h", a, v, d, model_mem[a]); end
    end
  endtask

  task automatic test_fetch_during_load();
    logic [7:0] bq[$];
    logic [31:0] d;
    logic [31:0] prev;
    logic v;
    do_fetch(3'd2, prev, v);
    bq = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    foreach (bq[i]) begin
      load_byte_valid = 1'b1;
      load_byte = bq[i];
      step();
    end
    load_byte_valid = 1'b0;
    fetch_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      fetch_addr = 3'($urandom_range(0, 3));
      step();
      checks++; if (fetch_valid !== 1'b0 || fetch_data !== prev) begin failures++; $display("[TB] FAIL load_fetch_ignored got=%b/%h exp=0/%h", fetch_valid, fetch_data, prev); end
    end
    fetch_req = 1'b0;
    load_end = 1'b1;
    step();
    load_end = 1'b0;
    repeat (3) step();
    model_load(bq);
    checks++; if (load_words !== 4'(model_words)) begin failures++; $display("[TB] FAIL load_fetch_words got=%0d exp=%0d", load_words, model_words); end
    do_fetch(3'(DEPTH), d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("[TB] FAIL fetch_depth got=%b/%h exp=1/0", v, d); end
    do_fetch(3'($urandom_range(DEPTH, 7)), d, v);
    checks++; if (v !== 1'b1 || d !== 32'h0) begin failures++; $display("[TB] FAIL fetch_out_of_range got=%b/%h exp=1/0", v, d); end
    do_fetch(3'd0, d, v);
    checks++; if (v !== 1'b1 || d !== model_mem[0]) begin failures++; $display("[TB] FAIL load_fetch_word0 got=%b/%h exp=1/%h", v, d, model_mem[0]); end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] bq[$];
    logic [7:0] kept[$];
    logic [31:0] d;
    logic v;
    for (int i = 0; i < 6; i++) bq.push_back(8'($urandom_range(0, 255)));
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    foreach (bq[i]) begin
      load_byte_valid = 1'b1;
      load_byte = bq[i];
      step();
    end
    load_byte_valid = 1'b0;
    rstn = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || load_ready !== 1'b0) begin failures++; $display("[TB] FAIL midreset_idle got=%b/%b exp=0/0", busy, load_ready); end
    checks++; if (load_words !== '0) begin failures++; $display("[TB] FAIL midreset_words got=%0d exp=0", load_words); end
    checks++; if (fetch_valid !== 1'b0 || fetch_data !== 32'h0) begin failures++; $display("[TB] FAIL midreset_fetch got=%b/%h exp=0/0", fetch_valid, fetch_data); end
    rstn = 1'b1;
    step();
    kept = bq[0:NB-1];
    model_load(kept);
    model_words = 0;
    do_fetch(3'd0, d, v);
    checks++; if (v !== 1'b1 || d !== model_mem[0]) begin failures++; $display("[TB] FAIL midreset_word0 got=%b/%h exp=1/%h", v, d, model_mem[0]); end
    do_fetch(3'd1, d, v);
    checks++; if (v !== 1'b1 || d !== model_mem[1]) begin failures++; $display("[TB] FAIL midreset_word1 got=%b/%h exp=1/%h", v, d, model_mem[1]); end
    checks++; if (load_words !== '0) begin failures++; $display("[TB] FAIL midreset_words_hold got=%0d exp=0", load_words); end
  endtask

  task automatic test_start_with_fetch();
    logic [ADDR_W-1:0] a;
    a = 3'($urandom_range(0, DEPTH - 1));
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = a;
    step();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    checks++; if (fetch_valid !== 1'b1 || fetch_data !== model_mem[a]) begin failures++; $display("[TB] FAIL start_fetch got=%b/%h exp=1/%h", fetch_valid, fetch_data, model_mem[a]); end
    checks++; if (busy !== 1'b1 || load_ready !== 1'b1) begin failures++; $display("[TB] FAIL start_busy got=%b/%b exp=1/1", busy, load_ready); end
    checks++; if (load_words !== '0) begin failures++; $display("[TB] FAIL start_words got=%0d exp=0", load_words); end
    load_end = 1'b1;
    step();
    load_end = 1'b0;
    checks++; if (load_done !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL empty_end got=%b/%b exp=1/0", load_done, busy); end
    step();
    checks++; if (load_done !== 1'b0) begin failures++; $display("[TB] FAIL empty_done_pulse got=%b exp=0", load_done); end
    model_words = 0;
  endtask

  task automatic test_random_loads();
    logic [7:0] bq[$];
    logic [31:0] d;
    logic v;
    int n;
    bit merge;
    for (int it = 0; it < 8; it++) begin
      bq.delete();
      n = $urandom_range(0, 18);
      for (int i = 0; i < n; i++) bq.push_back(8'($urandom_range(0, 255)));
      merge = (n > 0) && ($urandom_range(0, 1) == 1);
      run_load(bq, merge, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      model_load(bq);
      checks++; if (done_cnt !== 1) begin failures++; $display("[TB] FAIL rand%0d_done_pulses got=%0d exp=1", it, done_cnt); end
      checks++; if (load_words !== 4'(model_words) || busy !== 1'b0) begin failures++; $display("[TB] FAIL rand%0d_words got=%0d/%b exp=%0d/0", it, load_words, busy, model_words); end
      for (int a = 0; a < DEPTH; a++) begin
        if (model_wr[a]) begin
          do_fetch(3'(a), d, v);
          checks++; if (v !== 1'b1 || d !== model_mem[a]) begin failures++; $display("[TB] FAIL rand%0d_fetch%0d got=%b/%h exp=1/%h", it, a, v, d, model_mem[a]); end
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      model_wr[i]  = 1'b0;
    end
    model_words = 0;
    test_reset();
    test_basic_load();
    test_flush();
    test_full();
    test_fetch_during_load();
    test_reset_mid_load();
    test_start_with_fetch();
    test_random_loads();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
